// File: rtl/floating_point_multiplier_stream.sv
// Streaming floating-point multiplier with valid/ready handshake.
// Stage 1 classifies the operands and forms the raw mantissa product.
// Stage 2 normalises, rounds to nearest even and packs the result.
// Any further stages are plain retiming registers carrying the packed result.
`timescale 1ns/1ps
module floating_point_multiplier_stream #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRAC_WIDTH  = 23,
    parameter int PIPE_STAGES = 3,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]   fp_a_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]   fp_b_i,
    input  logic [TAG_WIDTH-1:0]            tag_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]   fp_o,
    output logic [TAG_WIDTH-1:0]            tag_o,
    output logic [3:0]                      flags_o
);

    localparam int W     = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int P     = FRAC_WIDTH + 1;
    localparam int EW    = EXP_WIDTH + 3;
    localparam int N_RET = PIPE_STAGES - 1;

    localparam logic signed [EW-1:0] BIAS_S = EW'(2 ** (EXP_WIDTH - 1) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'(2 ** EXP_WIDTH - 1);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic [FRAC_WIDTH-1:0] QNAN_FRAC = {1'b1, {(FRAC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } op_class_e;

    // Single global advance: every stage moves together or holds together.
    logic adv;
    assign adv     = !valid_o || ready_i;
    assign ready_o = adv;

    // ---------------------------------------------------------------- stage 1
    logic                   sign_a, sign_b;
    logic [EXP_WIDTH-1:0]   exp_a, exp_b;
    logic [FRAC_WIDTH-1:0]  frac_a, frac_b;
    logic                   zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    op_class_e              cls_c;
    logic [2*P-1:0]         prod_c;
    logic signed [EW-1:0]   exp_c;

    assign {sign_a, exp_a, frac_a} = fp_a_i;
    assign {sign_b, exp_b, frac_b} = fp_b_i;

    // Classify operands (exp==0 is zero, so subnormals flush) and form the raw product.
    always_comb begin
        zero_a = (exp_a == '0);
        zero_b = (exp_b == '0);
        inf_a  = (exp_a == '1) && (frac_a == '0);
        inf_b  = (exp_b == '1) && (frac_b == '0);
        nan_a  = (exp_a == '1) && (frac_a != '0);
        nan_b  = (exp_b == '1) && (frac_b != '0);
        cls_c  = CLS_NORMAL;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
            cls_c = CLS_NAN;
        else if (inf_a || inf_b)
            cls_c = CLS_INF;
        else if (zero_a || zero_b)
            cls_c = CLS_ZERO;
        prod_c = {{P{1'b0}}, 1'b1, frac_a} * {{P{1'b0}}, 1'b1, frac_b};
        exp_c  = $signed({3'b000, exp_a}) + $signed({3'b000, exp_b}) - BIAS_S;
    end

    logic                   s1_valid;
    logic                   s1_sign;
    op_class_e              s1_cls;
    logic [2*P-1:0]         s1_prod;
    logic signed [EW-1:0]   s1_exp;
    logic [TAG_WIDTH-1:0]   s1_tag;

    // Stage 1 register: captures a new op (or a bubble) whenever the pipe advances.
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= CLS_ZERO;
            s1_prod  <= '0;
            s1_exp   <= '0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= valid_i;
            s1_sign  <= sign_a ^ sign_b;
            s1_cls   <= cls_c;
            s1_prod  <= prod_c;
            s1_exp   <= exp_c;
            s1_tag   <= tag_i;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic                   hi;
    logic [P-1:0]           mant_pre;
    logic                   guard, sticky, round_up;
    logic [P:0]             mant_r;
    logic signed [EW-1:0]   exp_n, exp_r;
    logic [FRAC_WIDTH-1:0]  frac_r;
    logic [W-1:0]           res_fp;
    logic [3:0]             res_flags;

    // Normalise, round to nearest even, then apply the post-rounding exponent bounds.
    always_comb begin
        hi       = s1_prod[2*P-1];
        mant_pre = hi ? s1_prod[2*P-1:P] : s1_prod[2*P-2:P-1];
        guard    = hi ? s1_prod[P-1] : s1_prod[P-2];
        sticky   = hi ? (|s1_prod[P-2:0]) : (|s1_prod[P-3:0]);
        exp_n    = s1_exp + (hi ? ONE_S : ZERO_S);
        round_up = guard && (sticky || mant_pre[0]);
        mant_r   = {1'b0, mant_pre} + {{P{1'b0}}, round_up};
        if (mant_r[P]) begin
            frac_r = mant_r[P-1:1];
            exp_r  = exp_n + ONE_S;
        end else begin
            frac_r = mant_r[P-2:0];
            exp_r  = exp_n;
        end
        res_fp    = '0;
        res_flags = 4'b0000;
        unique case (s1_cls)
            CLS_NAN:  begin
                res_fp    = {1'b0, {EXP_WIDTH{1'b1}}, QNAN_FRAC};
                res_flags = 4'b1000;
            end
            CLS_INF:  res_fp = {s1_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            CLS_ZERO: res_fp = {s1_sign, {(W-1){1'b0}}};
            default: begin
                if (exp_r >= EMAX_S) begin
                    res_fp    = {s1_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
                    res_flags = 4'b0101;
                end else if (exp_r <= ZERO_S) begin
                    res_fp    = {s1_sign, {(W-1){1'b0}}};
                    res_flags = 4'b0011;
                end else begin
                    res_fp    = {s1_sign, exp_r[EXP_WIDTH-1:0], frac_r};
                    res_flags = {3'b000, guard | sticky};
                end
            end
        endcase
    end

    logic                 pipe_valid [N_RET];
    logic [W-1:0]         pipe_fp    [N_RET];
    logic [TAG_WIDTH-1:0] pipe_tag   [N_RET];
    logic [3:0]           pipe_flags [N_RET];

    // Result register followed by retiming stages; the last one drives the outputs.
    // NOTE: data registers are reset too, because the outputs must read as zero out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < N_RET; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_fp[i]    <= '0;
                pipe_tag[i]   <= '0;
                pipe_flags[i] <= '0;
            end
        end else if (adv) begin
            pipe_valid[0] <= s1_valid;
            pipe_fp[0]    <= res_fp;
            pipe_tag[0]   <= s1_tag;
            pipe_flags[0] <= res_flags;
            for (int i = 1; i < N_RET; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_fp[i]    <= pipe_fp[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
                pipe_flags[i] <= pipe_flags[i-1];
            end
        end
    end

    assign valid_o = pipe_valid[N_RET-1];
    assign fp_o    = pipe_fp[N_RET-1];
    assign tag_o   = pipe_tag[N_RET-1];
    assign flags_o = pipe_flags[N_RET-1];

endmodule

// File: tb/tb_floating_point_multiplier_stream.sv
// Self-checking bench for floating_point_multiplier_stream (binary32, 3 stages).
// Directed vectors use fixed expected values; random streams use an integer
// reference model that rounds with plain quotient/remainder arithmetic.
`timescale 1ns/1ps
module tb_floating_point_multiplier_stream;

    typedef struct {
        logic [31:0] fp;
        logic [3:0]  tag;
        logic [3:0]  flags;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] fp_a_i = '0;
    logic [31:0] fp_b_i = '0;
    logic [3:0]  tag_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] fp_o;
    logic [3:0]  tag_o;
    logic [3:0]  flags_o;

    int total = 0;
    int bad   = 0;

    floating_point_multiplier_stream #(
        .EXP_WIDTH(8), .FRAC_WIDTH(23), .PIPE_STAGES(3), .TAG_WIDTH(4)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
        .fp_a_i(fp_a_i), .fp_b_i(fp_b_i), .tag_i(tag_i), .valid_o(valid_o),
        .ready_i(ready_i), .fp_o(fp_o), .tag_o(tag_o), .flags_o(flags_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the remainder to half an ulp.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        exp_t   r;
        int     ea, eb, e, sh;
        bit     sgn, za, zb, ia, ib, na, nb;
        longint m, q, rem, half;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        sgn = a[31] ^ b[31];
        za  = (ea == 0);
        zb  = (eb == 0);
        ia  = (ea == 255) && (a[22:0] == 0);
        ib  = (eb == 255) && (b[22:0] == 0);
        na  = (ea == 255) && (a[22:0] != 0);
        nb  = (eb == 255) && (b[22:0] != 0);
        r.tag = tag;
        if (na || nb || (ia && zb) || (ib && za)) begin
            r.fp = 32'h7FC00000; r.flags = 4'b1000;
        end else if (ia || ib) begin
            r.fp = {sgn, 8'hFF, 23'h0}; r.flags = 4'b0000;
        end else if (za || zb) begin
            r.fp = {sgn, 31'h0}; r.flags = 4'b0000;
        end else begin
            m    = (longint'(a[22:0]) + (longint'(1) << 23)) * (longint'(b[22:0]) + (longint'(1) << 23));
            sh   = (m >= (longint'(1) << 47)) ? 24 : 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            e    = ea + eb - 127 + (sh - 23);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                r.fp = {sgn, 8'hFF, 23'h0}; r.flags = 4'b0101;
            end else if (e <= 0) begin
                r.fp = {sgn, 31'h0}; r.flags = 4'b0011;
            end else begin
                r.fp = {sgn, 8'(e), q[22:0]}; r.flags = {3'b000, rem != 0};
            end
        end
        return r;
    endfunction

    // Operands biased towards zero, Inf/NaN and both exponent extremes.
    function automatic logic [31:0] rand_operand();
        logic [7:0]  e;
        logic [22:0] f;
        int          pick;
        pick = $urandom_range(0, 15);
        f    = 23'($urandom);
        if (pick == 0)      e = 8'h00;
        else if (pick == 1) e = 8'hFF;
        else if (pick < 6)  e = 8'($urandom_range(200, 254));
        else if (pick < 10) e = 8'($urandom_range(1, 60));
        else                e = 8'($urandom_range(100, 154));
        if ($urandom_range(0, 3) == 0) f = '0;
        return {1'($urandom), e, f};
    endfunction

    // One op through an empty pipe with ready_i held high; checks exact latency.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] efp, input logic [3:0] eflags);
        @(negedge clk_i);
        ready_i = 1'b1;
        valid_i = 1'b1;
        fp_a_i  = a;
        fp_b_i  = b;
        tag_i   = tag;
        #1 check({name, "_ready"}, 64'(ready_o), 64'd1);
        @(negedge clk_i);
        valid_i = 1'b0;
        check({name, "_lat1"}, 64'(valid_o), 64'd0);
        @(negedge clk_i);
        check({name, "_lat2"}, 64'(valid_o), 64'd0);
        @(negedge clk_i);
        check({name, "_valid"}, 64'(valid_o), 64'd1);
        check({name, "_fp"}, 64'(fp_o), 64'(efp));
        check({name, "_tag"}, 64'(tag_o), 64'(tag));
        check({name, "_flags"}, 64'(flags_o), 64'(eflags));
        @(negedge clk_i);
        check({name, "_drain"}, 64'(valid_o), 64'd0);
    endtask

    // Streams n random ops back to back, scoring in-order results and stall stability.
    task automatic stream_ops(input string name, input int n, input bit bp);
        exp_t        q[$];
        exp_t        e;
        int          sent = 0, got = 0, cyc = 0;
        bit          stalled = 0;
        logic [31:0] held_fp;
        logic [3:0]  held_tag, held_flags;
        logic [31:0] a, b;
        a = rand_operand();
        b = rand_operand();
        while (got < n && cyc < 20 * n + 50) begin
            @(negedge clk_i);
            cyc++;
            if (stalled) begin
                check({name, "_hold_valid"}, 64'(valid_o), 64'd1);
                check({name, "_hold_fp"}, 64'(fp_o), 64'(held_fp));
                check({name, "_hold_tag"}, 64'(tag_o), 64'(held_tag));
                check({name, "_hold_flags"}, 64'(flags_o), 64'(held_flags));
            end
            ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            valid_i = (sent < n);
            fp_a_i  = a;
            fp_b_i  = b;
            tag_i   = 4'(sent);
            #1;
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    check({name, "_spurious"}, 64'(valid_o), 64'd0);
                end else begin
                    e = q.pop_front();
                    check({name, "_fp"}, 64'(fp_o), 64'(e.fp));
                    check({name, "_tag"}, 64'(tag_o), 64'(e.tag));
                    check({name, "_flags"}, 64'(flags_o), 64'(e.flags));
                end
                got++;
            end
            if (valid_i && ready_o) begin
                q.push_back(model(a, b, 4'(sent)));
                sent++;
                a = rand_operand();
                b = rand_operand();
            end
            stalled    = valid_o && !ready_i;
            held_fp    = fp_o;
            held_tag   = tag_o;
            held_flags = flags_o;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        check({name, "_count"}, 64'(got), 64'(n));
        check({name, "_leftover"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        int seen;
        // Reset state, sampled while reset is held.
        #3;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_fp", 64'(fp_o), 64'd0);
        check("rst_tag", 64'(tag_o), 64'd0);
        check("rst_flags", 64'(flags_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("rst_ready_after", 64'(ready_o), 64'd1);

        // Directed vectors.
        run_op("basic",     32'h3FC00000, 32'h40000000, 4'd5, 32'h40400000, 4'b0000);
        run_op("rne_odd",   32'h3F800001, 32'h3FC00000, 4'd1, 32'h3FC00002, 4'b0001);
        run_op("rne_even",  32'h3F800003, 32'h3FC00000, 4'd2, 32'h3FC00004, 4'b0001);
        run_op("overflow",  32'h7F000000, 32'h40000000, 4'd3, 32'h7F800000, 4'b0101);
        run_op("inf_zero",  32'h7F800000, 32'h00000000, 4'd4, 32'h7FC00000, 4'b1000);
        run_op("underflow", 32'h00800000, 32'h3F000000, 4'd6, 32'h00000000, 4'b0011);
        run_op("subnormal", 32'h80000001, 32'h3F800000, 4'd7, 32'h80000000, 4'b0000);
        run_op("inf_neg",   32'hFF800000, 32'h40000000, 4'd8, 32'hFF800000, 4'b0000);
        run_op("nan_in",    32'h7F800001, 32'h3F800000, 4'd9, 32'h7FC00000, 4'b1000);

        // Backpressure and random coverage against the model.
        stream_ops("bp8", 8, 1'b1);
        stream_ops("full", 60, 1'b0);
        stream_ops("rand", 200, 1'b1);

        // Reset with three ops in flight.
        @(negedge clk_i);
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid_i = 1'b1;
            fp_a_i  = 32'h3F800000 + 32'(k);
            fp_b_i  = 32'h40000000;
            tag_i   = 4'(k + 10);
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        check("inflight_valid", 64'(valid_o), 64'd1);
        rst_n_i = 1'b0;
        #1;
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_fp", 64'(fp_o), 64'd0);
        check("midrst_tag", 64'(tag_o), 64'd0);
        check("midrst_flags", 64'(flags_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        ready_i = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (valid_o) seen++;
        end
        check("postrst_none", 64'(seen), 64'd0);
        run_op("postrst", 32'h3FC00000, 32'h40000000, 4'd5, 32'h40400000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
